// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: instruction memory, redirect and decode handshake
interface fetch_unit_if #(
  parameter int ADDR_W  = 6,
  parameter int INSTR_W = 16
);
  logic               fetch_en;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [INSTR_W-1:0] out_imm;
  logic               out_two_word;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    input  fetch_en, mem_data, redirect_valid, redirect_pc, out_ready,
    output mem_addr, out_valid, out_instr, out_imm, out_two_word, out_pc
  );

  modport slave (
    output fetch_en, mem_data, redirect_valid, redirect_pc, out_ready,
    input  mem_addr, out_valid, out_instr, out_imm, out_two_word, out_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencer that assembles one- and two-word instruction bundles for decode
module fetch_unit #(
  parameter int              ADDR_W   = 6,
  parameter int              INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter logic [3:0]      MVI_OP   = 4'b0100
) (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    FETCH_IMM = 2'd1,
    HOLD      = 2'd2
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc;

  // Memory is combinational, so the PC register addresses it directly.
  assign bus.mem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= FETCH;
      pc               <= PC_RESET;
      bus.out_valid    <= 1'b0;
      bus.out_instr    <= '0;
      bus.out_imm      <= '0;
      bus.out_two_word <= 1'b0;
      bus.out_pc       <= '0;
    end else if (bus.redirect_valid) begin
      // Redirect wins over everything, including a handshake in the same cycle.
      state            <= FETCH;
      pc               <= bus.redirect_pc;
      bus.out_valid    <= 1'b0;
      bus.out_two_word <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.fetch_en) begin
            bus.out_instr <= bus.mem_data;
            bus.out_pc    <= pc;
            pc            <= pc + 1'b1;
            if (bus.mem_data[15:12] == MVI_OP) begin
              bus.out_two_word <= 1'b1;
              state            <= FETCH_IMM;
            end else begin
              bus.out_two_word <= 1'b0;
              bus.out_imm      <= '0;
              bus.out_valid    <= 1'b1;
              state            <= HOLD;
            end
          end
        end
        FETCH_IMM: begin
          if (bus.fetch_en) begin
            bus.out_imm   <= bus.mem_data;
            pc            <= pc + 1'b1;
            bus.out_valid <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= FETCH;
          end
        end
        default: begin
          state         <= FETCH;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a combinational memory model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] mem [64];

  fetch_unit_if #(.ADDR_W(6), .INSTR_W(16)) bus ();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.mem_data = mem[bus.mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bundle(input string tag, input logic [15:0] instr, input logic [15:0] imm,
                            input logic two, input logic [5:0] pc);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(1'b1));
    chk({tag, "_instr"}, 32'(bus.out_instr), 32'(instr));
    chk({tag, "_imm"},   32'(bus.out_imm),   32'(imm));
    chk({tag, "_two"},   32'(bus.out_two_word), 32'(two));
    chk({tag, "_pc"},    32'(bus.out_pc),    32'(pc));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[0] = 16'h4400; mem[1] = 16'h0001; mem[2] = 16'h4800; mem[3] = 16'h000A;
    mem[4] = 16'h0BC0; mem[5] = 16'h6880; mem[6] = 16'h2F40; mem[63] = 16'h4000;
    bus.fetch_en = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;

    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_addr",  32'(bus.mem_addr),  32'd0);
    chk("rst_instr", 32'(bus.out_instr), 32'd0);
    chk("rst_two",   32'(bus.out_two_word), 32'd0);
    chk("rst_pc",    32'(bus.out_pc),    32'd0);
    rst = 1'b0;

    // MVI pair at 0/1, then 2/3
    step();
    chk("mvi0_wait_valid", 32'(bus.out_valid), 32'd0);
    chk("mvi0_wait_addr",  32'(bus.mem_addr),  32'd1);
    step();
    chk_bundle("mvi0", 16'h4400, 16'h0001, 1'b1, 6'd0);
    step();
    chk("mvi0_accept_valid", 32'(bus.out_valid), 32'd0);
    step();
    step();
    chk_bundle("mvi2", 16'h4800, 16'h000A, 1'b1, 6'd2);

    // single-word bundles
    step();
    step();
    chk_bundle("sw4", 16'h0BC0, 16'h0000, 1'b0, 6'd4);
    step();
    step();
    chk_bundle("sw5", 16'h6880, 16'h0000, 1'b0, 6'd5);

    // backpressure
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_instr", 32'(bus.out_instr), 32'h6880);
      chk("bp_pc",    32'(bus.out_pc),    32'd5);
      chk("bp_addr",  32'(bus.mem_addr),  32'd6);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_addr",  32'(bus.mem_addr),  32'd6);
    step();
    chk_bundle("sw6", 16'h2F40, 16'h0000, 1'b0, 6'd6);

    // redirect coincident with acceptance in HOLD
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 6'd4;
    step();
    bus.redirect_valid = 1'b0;
    chk("rd_hold_valid", 32'(bus.out_valid), 32'd0);
    chk("rd_hold_addr",  32'(bus.mem_addr),  32'd4);
    step();
    chk_bundle("rd_hold_sw4", 16'h0BC0, 16'h0000, 1'b0, 6'd4);
    step();

    // redirect to an MVI, then abandon it in FETCH_IMM
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 6'd2;
    step();
    bus.redirect_valid = 1'b0;
    step();
    chk("rd_imm_pre_valid", 32'(bus.out_valid), 32'd0);
    chk("rd_imm_pre_addr",  32'(bus.mem_addr),  32'd3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 6'd5;
    step();
    bus.redirect_valid = 1'b0;
    chk("rd_imm_valid", 32'(bus.out_valid), 32'd0);
    chk("rd_imm_two",   32'(bus.out_two_word), 32'd0);
    chk("rd_imm_addr",  32'(bus.mem_addr), 32'd5);
    step();
    chk_bundle("rd_imm_sw5", 16'h6880, 16'h0000, 1'b0, 6'd5);
    step();

    // fetch_en low freezes FETCH
    bus.fetch_en = 1'b0;
    step();
    step();
    chk("freeze_valid", 32'(bus.out_valid), 32'd0);
    chk("freeze_addr",  32'(bus.mem_addr),  32'd6);
    bus.fetch_en = 1'b1;

    // MVI at 63 wraps to 0 for its immediate
    mem[0] = 16'h0005;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 6'd63;
    step();
    bus.redirect_valid = 1'b0;
    chk("wrap_addr63", 32'(bus.mem_addr), 32'd63);
    step();
    chk("wrap_addr0", 32'(bus.mem_addr), 32'd0);
    step();
    chk_bundle("wrap", 16'h4000, 16'h0005, 1'b1, 6'd63);
    chk("wrap_addr1", 32'(bus.mem_addr), 32'd1);

    // async reset in FETCH_IMM
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 6'd2;
    step();
    bus.redirect_valid = 1'b0;
    step();
    chk("ar_pre_two",  32'(bus.out_two_word), 32'd1);
    chk("ar_pre_addr", 32'(bus.mem_addr), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_addr",  32'(bus.mem_addr),  32'd0);
    chk("ar_two",   32'(bus.out_two_word), 32'd0);
    chk("ar_instr", 32'(bus.out_instr), 32'd0);
    #2 rst = 1'b0;
    step();
    chk_bundle("ar_first", 16'h0005, 16'h0000, 1'b0, 6'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the decode/execute datapath and directly drives the address input of the page-translating instruction memory (6-bit virtual address in, 16-bit word out, combinational read).
- Holds the PC and sequences one- and two-word instructions. MVI is opcode 4'b0100 and is followed by an immediate word.
- Presents each complete instruction, with its immediate and PC, to decode over a valid/ready handshake.
- Accepts PC redirects from execute (writes to R7, taken MVNZ R7).

Parameters:
ADDR_W, 6, PC / memory address width
INSTR_W, 16, instruction word width
PC_RESET, 0, PC value loaded on reset
MVI_OP, 4'b0100, opcode in bits [15:12] that marks a two-word instruction

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
fetch_en  input  1  1 = fetch allowed; 0 = freeze in FETCH/FETCH_IMM (no PC advance)
mem_addr  output  ADDR_W  address to instruction memory (= pc, combinational from register)
mem_data  input  INSTR_W  word returned by instruction memory for mem_addr (same cycle)
redirect_valid  input  1  load new PC, flush in-flight instruction
redirect_pc  input  ADDR_W  target PC
out_valid  output  1  instruction bundle valid to decode
out_ready  input  1  decode accepts bundle
out_instr  output  INSTR_W  first instruction word
out_imm  output  INSTR_W  immediate word (0 when out_two_word=0)
out_two_word  output  1  1 when bundle is an MVI with immediate
out_pc  output  ADDR_W  address of the first word of the bundle

Behaviour:
- Reset (async, immediate): pc=PC_RESET, state=FETCH, out_valid=0, out_instr=0, out_imm=0, out_two_word=0, out_pc=0. mem_addr follows pc, so mem_addr=PC_RESET during reset.
- FSM states: FETCH, FETCH_IMM, HOLD. mem_addr = pc at all times.
- FETCH, fetch_en=1, at edge:
  - out_instr<=mem_data; out_pc<=pc; pc<=pc+1.
  - If mem_data[15:12]==MVI_OP: out_two_word<=1, go to FETCH_IMM.
  - Else: out_two_word<=0, out_imm<=0, out_valid<=1, go to HOLD.
- FETCH_IMM, fetch_en=1, at edge: out_imm<=mem_data; pc<=pc+1; out_valid<=1; go to HOLD.
- fetch_en=0 in FETCH or FETCH_IMM: all registers hold. Words already captured are retained.
- HOLD: out_valid=1 and all out_* stable until accepted. At an edge with out_ready=1: out_valid<=0, go to FETCH. pc is not touched in HOLD; fetch_en is ignored in HOLD.
- Latency: single-word instruction valid 1 edge after FETCH entry; MVI valid 2 edges after FETCH entry. Peak throughput 1 bundle per 2 cycles (single-word), 1 per 3 (MVI).
- Redirect, highest priority, any state, at edge: pc<=redirect_pc; out_valid<=0; out_two_word<=0; go to FETCH.
  - A bundle in HOLD is discarded even if out_ready=1 in the same cycle; decode must ignore a handshake coincident with redirect.
  - A half-fetched MVI in FETCH_IMM is abandoned.
- PC arithmetic: modulo 2^ADDR_W. pc=63+1 -> 0. An MVI at address 63 takes its immediate from address 0.
- Reset mid-operation (any state, including HOLD with out_ready high): returns to reset values immediately; no bundle is produced.
- Unknown opcodes are treated as single-word; no decode-time checking here.

Test Plan:
- Memory holds 0:0x4400, 1:0x0001, 2:0x4800, 3:0x000A; release Reset, out_ready=1 -> after 2 edges out_valid=1, out_instr=0x4400, out_imm=0x0001, out_two_word=1, out_pc=0. Next bundle is 0x4800/0x000A, out_pc=2.
- Single-word: mem[4]=0x0BC0, mem[5]=0x6880 -> bundles out_instr=0x0BC0, out_pc=4, out_two_word=0, out_imm=0; then 0x6880, out_pc=5, one edge each after FETCH entry.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_valid stays 1, out_* and mem_addr unchanged. Raise out_ready -> out_valid drops next edge and the next fetch starts from pc+1.
- Redirect: in HOLD with bundle pc=6 (0x2F40), assert redirect_valid with redirect_pc=4 and out_ready=1 in the same cycle -> bundle dropped, next bundle out_pc=4, out_instr=0x0BC0. Repeat with redirect during FETCH_IMM -> the MVI is abandoned.
- Wrap: redirect_pc=63, mem[63]=0x4000, mem[0]=0x0005 -> bundle out_pc=63, out_instr=0x4000, out_imm=0x0005; mem_addr then equals 1.
- Async reset asserted mid-clock while in FETCH_IMM -> out_valid=0 and mem_addr=0 immediately, before the next edge. After release, first bundle has out_pc=0.
